// File: rtl/bus_pkg.sv
// Shared definitions for the crypto interconnect: module IDs, header field
// positions and the transaction scheduler state encoding. The data-bus block
// imports the same constants so both sides agree on the header layout.
package bus_pkg;

   localparam logic [1:0] ID_CTRL      = 2'd3;
   localparam int         NUM_REQ      = 3;
   localparam int         HDR_SRC_LSB  = 2;
   localparam int         HDR_DEST_LSB = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_WAIT,
      ST_XFER,
      ST_ACK
   } arb_state_t;

   // Header byte is {2'b00, dest, src, 2'b00}
   function automatic logic [7:0] make_header(input logic [1:0] src, input logic [1:0] dest);
      logic [7:0] h;
      h = '0;
      h[HDR_SRC_LSB +: 2]  = src;
      h[HDR_DEST_LSB +: 2] = dest;
      return h;
   endfunction

   // Converts the arbiter's one-hot winner into a requester ID
   function automatic logic [1:0] onehot_to_id(input logic [NUM_REQ-1:0] oh);
      logic [1:0] id;
      id = 2'd0;
      if (oh[1]) begin
         id = 2'd1;
      end else if (oh[2]) begin
         id = 2'd2;
      end
      return id;
   endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Request, header and bus-monitor signals between the transaction scheduler
// and the requesters / control port. The scheduler uses the master view.
interface bus_arbiter_if;
   import bus_pkg::*;

   logic [NUM_REQ-1:0]   req;
   logic [2*NUM_REQ-1:0] req_dest;
   logic [8*NUM_REQ-1:0] req_len;
   logic [NUM_REQ-1:0]   grant;
   logic                 hdr_valid;
   logic [7:0]           hdr_data;
   logic                 hdr_ready;
   logic                 mon_valid;
   logic                 ack;
   logic                 busy;
   logic                 err_timeout;
   logic                 err_illegal;

   modport master (
      input  req, req_dest, req_len, hdr_ready, mon_valid,
      output grant, hdr_valid, hdr_data, ack, busy, err_timeout, err_illegal
   );

   modport slave (
      output req, req_dest, req_len, hdr_ready, mon_valid,
      input  grant, hdr_valid, hdr_data, ack, busy, err_timeout, err_illegal
   );

endinterface

// File: rtl/bus_arbiter_rr_arbiter.sv
// Three-way round-robin priority encoder. The search begins at the requester
// after the last owner, so every ID gets a turn while others keep requesting.
module rr_arbiter
   import bus_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [1:0]         last,
   output logic [NUM_REQ-1:0] winner,
   output logic               any
);

   // Pick the first active request in rotated order starting at last+1
   always_comb begin
      winner = '0;
      case (last)
         2'd0: begin
            if      (req[1]) winner = 3'b010;
            else if (req[2]) winner = 3'b100;
            else if (req[0]) winner = 3'b001;
         end
         2'd1: begin
            if      (req[2]) winner = 3'b100;
            else if (req[0]) winner = 3'b001;
            else if (req[1]) winner = 3'b010;
         end
         default: begin
            if      (req[0]) winner = 3'b001;
            else if (req[1]) winner = 3'b010;
            else if (req[2]) winner = 3'b100;
         end
      endcase
   end

   assign any = |req;

endmodule

// File: rtl/bus_arbiter.sv
// Transaction scheduler for the shared crypto bus. Picks a requester
// round-robin, sends its header through the control port, waits for the
// owner to take the bus, counts payload beats and closes each transaction
// with a one-cycle ack. A watchdog closes transactions whose owner stalls.
module bus_arbiter
   import bus_pkg::*;
#(
   parameter int TIMEOUT = 255
)(
   input logic           clk,
   input logic           rst_n,
   bus_arbiter_if.master bus
);

   localparam int             WD_W   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

   arb_state_t          state_q;
   arb_state_t          state_d;
   logic [1:0]          last_q;
   logic [1:0]          owner_q;
   logic [7:0]          len_q;
   logic [7:0]          beat_q;
   logic [WD_W-1:0]     wd_q;
   logic [1:0]          wait_q;
   logic [7:0]          hdr_q;
   logic                err_timeout_q;
   logic                err_illegal_q;

   logic [NUM_REQ-1:0]  win_oh;
   logic                win_any;
   logic [1:0]          win_id;
   logic [1:0]          win_dest;
   logic [7:0]          win_len;

   logic                take;
   logic                reject;
   logic                timeout;
   logic [7:0]          beat_inc;
   logic [WD_W-1:0]     wd_inc;

   rr_arbiter u_rr (
      .req    (bus.req),
      .last   (last_q),
      .winner (win_oh),
      .any    (win_any)
   );

   assign win_id   = onehot_to_id(win_oh);
   assign win_dest = bus.req_dest[{win_id, 1'b0} +: 2];
   assign win_len  = bus.req_len[{win_id, 3'b000} +: 8];

   // State register; reset aborts any transaction without an ack
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode plus the one-cycle events that steer the datapath
   always_comb begin
      state_d  = state_q;
      take     = 1'b0;
      reject   = 1'b0;
      timeout  = 1'b0;
      beat_inc = beat_q + 8'd1;
      wd_inc   = wd_q + 1'b1;
      case (state_q)
         ST_IDLE: begin
            if (win_any) begin
               if (win_dest == win_id) begin
                  reject = 1'b1;
               end else begin
                  take    = 1'b1;
                  state_d = ST_HDR;
               end
            end
         end
         ST_HDR: begin
            if (bus.hdr_ready) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (wait_q == 2'd2) begin
               state_d = (len_q == 8'd0) ? ST_ACK : ST_XFER;
            end
         end
         ST_XFER: begin
            if (bus.mon_valid) begin
               if (beat_inc == len_q) begin
                  state_d = ST_ACK;
               end
            end else if (wd_inc == WD_MAX) begin
               timeout = 1'b1;
               state_d = ST_ACK;
            end
         end
         ST_ACK: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Captured transaction, beat/idle counters and the registered error pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q        <= 2'd2;
         owner_q       <= 2'd0;
         len_q         <= 8'd0;
         beat_q        <= 8'd0;
         wd_q          <= '0;
         wait_q        <= 2'd0;
         hdr_q         <= 8'd0;
         err_timeout_q <= 1'b0;
         err_illegal_q <= 1'b0;
      end else begin
         err_timeout_q <= timeout;
         err_illegal_q <= reject;
         if (take) begin
            owner_q <= win_id;
            len_q   <= win_len;
            hdr_q   <= make_header(win_id, win_dest);
         end
         if (reject) begin
            last_q <= win_id;
         end
         if (state_q == ST_ACK) begin
            last_q <= owner_q;
         end
         if (state_q == ST_WAIT) begin
            wait_q <= wait_q + 2'd1;
         end else begin
            wait_q <= 2'd0;
         end
         if (state_q == ST_XFER) begin
            if (bus.mon_valid) begin
               if (beat_q != 8'hFF) begin
                  beat_q <= beat_inc;
               end
               wd_q <= '0;
            end else if (wd_q != WD_MAX) begin
               wd_q <= wd_inc;
            end
         end else begin
            beat_q <= 8'd0;
            wd_q   <= '0;
         end
      end
   end

   assign bus.grant       = ((state_q == ST_HDR) || (state_q == ST_WAIT) || (state_q == ST_XFER))
                            ? (3'b001 << owner_q) : 3'b000;
   assign bus.hdr_valid   = (state_q == ST_HDR);
   assign bus.hdr_data    = hdr_q;
   assign bus.ack         = (state_q == ST_ACK);
   assign bus.busy        = (state_q != ST_IDLE);
   assign bus.err_timeout = err_timeout_q;
   assign bus.err_illegal = err_illegal_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Testbench for bus_arbiter. Stimulus pushes the expected header/ack/error
// events into a queue; a monitor pops and compares them as the DUT shows
// them. Cycle-exact timing is checked directly by the stimulus process.
module tb_bus_arbiter;

   localparam int EV_HDR = 0;
   localparam int EV_ACK = 1;
   localparam int EV_ILL = 2;
   localparam int EV_TMO = 3;

   typedef struct {
      int         kind;
      logic [7:0] data;
      logic [2:0] grant;
   } ev_t;

   logic clk;
   logic rst_n;
   int   compared;
   int   mismatched;
   ev_t  expq[$];

   bus_arbiter_if bus ();

   bus_arbiter #(.TIMEOUT(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Free-running clock, 10 time units per cycle
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int actual, input int expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic pushExp(input int kind, input logic [7:0] data, input logic [2:0] grant);
      ev_t e;
      e.kind  = kind;
      e.data  = data;
      e.grant = grant;
      expq.push_back(e);
   endtask

   task automatic applyStimulus(input logic [2:0] r, input logic [5:0] d, input logic [23:0] l);
      bus.req      = r;
      bus.req_dest = d;
      bus.req_len  = l;
   endtask

   task automatic observe(input int kind, input logic [7:0] data, input logic [2:0] grant);
      ev_t e;
      compared++;
      if (expq.size() == 0) begin
         mismatched++;
         $display("[TB] FAIL sb_unexpected: got kind=%0d data=%02h grant=%03b, expected no event",
                  kind, data, grant);
      end else begin
         e = expq.pop_front();
         if (e.kind != kind || e.data !== data || e.grant !== grant) begin
            mismatched++;
            $display("[TB] FAIL sb_event: got kind=%0d data=%02h grant=%03b, expected kind=%0d data=%02h grant=%03b",
                     kind, data, grant, e.kind, e.data, e.grant);
         end
      end
   endtask

   // Monitor: samples mid-cycle, after the negedge drive has settled
   always @(negedge clk) begin
      #2;
      if (rst_n) begin
         if (bus.hdr_valid && bus.hdr_ready) observe(EV_HDR, bus.hdr_data, bus.grant);
         if (bus.ack) observe(EV_ACK, {7'd0, bus.err_timeout}, bus.grant);
         if (bus.err_illegal) observe(EV_ILL, 8'd0, bus.grant);
         if (bus.err_timeout && !bus.ack) observe(EV_TMO, 8'd1, bus.grant);
      end
   end

   task automatic doReset();
      rst_n         = 1'b0;
      bus.req       = '0;
      bus.req_dest  = '0;
      bus.req_len   = '0;
      bus.hdr_ready = 1'b1;
      bus.mon_valid = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("rst_grant", int'(bus.grant), 0);
      checkOutput("rst_hdr_valid", int'(bus.hdr_valid), 0);
      checkOutput("rst_hdr_data", int'(bus.hdr_data), 0);
      checkOutput("rst_ack", int'(bus.ack), 0);
      checkOutput("rst_busy", int'(bus.busy), 0);
      checkOutput("rst_errs", int'({bus.err_timeout, bus.err_illegal}), 0);
      rst_n = 1'b1;
   endtask

   // Holds the given requests with continuous beats until nAcks acks are seen
   task automatic serveRequests(input logic [2:0] mask, input int nAcks);
      int acks;
      int guard;
      int pendGap;
      acks    = 0;
      guard   = 0;
      pendGap = 0;
      bus.req       = mask;
      bus.mon_valid = 1'b1;
      while (acks < nAcks && guard < 400) begin
         @(negedge clk);
         guard++;
         if (pendGap == 1) begin
            checkOutput("gap_idle_busy", int'(bus.busy), 0);
            pendGap = 2;
         end else if (pendGap == 2) begin
            checkOutput("gap_next_hdr", int'(bus.hdr_valid), 1);
            pendGap = 0;
         end
         if (bus.ack) begin
            acks++;
            if (acks == nAcks) bus.req = '0;
            else pendGap = 1;
         end
      end
      bus.req       = '0;
      bus.mon_valid = 1'b0;
      checkOutput("serve_ack_count", acks, nAcks);
   endtask

   // Global time limit so the bench always ends on its own
   initial begin
      #100000;
      $display("[TB] FAIL global_timeout: got no finish, expected finish before limit");
      $fatal(1, "[TB] time limit reached");
   end

   initial begin
      compared   = 0;
      mismatched = 0;
      doReset();

      // Single transaction: ID0 -> dest 2, four beats, stray beats during HDR/WAIT
      @(negedge clk);
      applyStimulus(3'b001, 6'b000010, 24'h000004);
      pushExp(EV_HDR, 8'h20, 3'b001);
      pushExp(EV_ACK, 8'h00, 3'b000);
      @(negedge clk);
      checkOutput("t1_hdr_valid", int'(bus.hdr_valid), 1);
      checkOutput("t1_grant", int'(bus.grant), 1);
      checkOutput("t1_hdr_data", int'(bus.hdr_data), 8'h20);
      bus.req       = '0;
      bus.mon_valid = 1'b1;
      repeat (7) @(negedge clk);
      checkOutput("t1_ack_early", int'(bus.ack), 0);
      @(negedge clk);
      checkOutput("t1_ack", int'(bus.ack), 1);
      checkOutput("t1_ack_grant", int'(bus.grant), 0);
      bus.mon_valid = 1'b0;
      @(negedge clk);
      checkOutput("t1_ack_pulse", int'(bus.ack), 0);
      checkOutput("t1_busy_after", int'(bus.busy), 0);

      // Round robin with all three held, len 1 each
      doReset();
      @(negedge clk);
      applyStimulus(3'b000, 6'b001001, 24'h010101);
      pushExp(EV_HDR, 8'h10, 3'b001); pushExp(EV_ACK, 8'h00, 3'b000);
      pushExp(EV_HDR, 8'h24, 3'b010); pushExp(EV_ACK, 8'h00, 3'b000);
      pushExp(EV_HDR, 8'h08, 3'b100); pushExp(EV_ACK, 8'h00, 3'b000);
      pushExp(EV_HDR, 8'h10, 3'b001); pushExp(EV_ACK, 8'h00, 3'b000);
      serveRequests(3'b111, 4);

      // Header held while hdr_ready is low; ID1 -> dest 3 is legal
      @(negedge clk);
      bus.hdr_ready = 1'b0;
      applyStimulus(3'b010, 6'b001100, 24'h000200);
      pushExp(EV_HDR, 8'h34, 3'b010);
      pushExp(EV_ACK, 8'h00, 3'b000);
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         if (i == 1) bus.req = '0;
         checkOutput("t3_hdr_valid", int'(bus.hdr_valid), 1);
         checkOutput("t3_hdr_data", int'(bus.hdr_data), 8'h34);
         checkOutput("t3_grant", int'(bus.grant), 3'b010);
      end
      bus.hdr_ready = 1'b1;
      @(negedge clk);
      checkOutput("t3_wait_hdr_valid", int'(bus.hdr_valid), 0);
      checkOutput("t3_wait_grant", int'(bus.grant), 3'b010);
      repeat (3) @(negedge clk);
      bus.mon_valid = 1'b1;
      @(negedge clk);
      checkOutput("t3_ack_early", int'(bus.ack), 0);
      @(negedge clk);
      bus.mon_valid = 1'b0;
      checkOutput("t3_ack", int'(bus.ack), 1);

      // Watchdog: ID2 len 3, one beat then silence, TIMEOUT = 8
      @(negedge clk);
      applyStimulus(3'b100, 6'b010000, 24'h030000);
      pushExp(EV_HDR, 8'h18, 3'b100);
      pushExp(EV_ACK, 8'h01, 3'b000);
      @(negedge clk);
      bus.req = '0;
      checkOutput("t4_grant", int'(bus.grant), 3'b100);
      repeat (4) @(negedge clk);
      bus.mon_valid = 1'b1;
      @(negedge clk);
      bus.mon_valid = 1'b0;
      repeat (7) @(negedge clk);
      checkOutput("t4_ack_early", int'(bus.ack), 0);
      @(negedge clk);
      checkOutput("t4_ack", int'(bus.ack), 1);
      checkOutput("t4_err_timeout", int'(bus.err_timeout), 1);
      @(negedge clk);
      checkOutput("t4_err_timeout_pulse", int'(bus.err_timeout), 0);
      checkOutput("t4_busy_after", int'(bus.busy), 0);
      applyStimulus(3'b000, 6'b000010, 24'h000001);
      pushExp(EV_HDR, 8'h20, 3'b001);
      pushExp(EV_ACK, 8'h00, 3'b000);
      serveRequests(3'b001, 1);

      // Illegal request: ID1 -> dest 1 rejected, then ID0 wins since last is 1
      @(negedge clk);
      applyStimulus(3'b010, 6'b000100, 24'h000100);
      pushExp(EV_ILL, 8'h00, 3'b000);
      @(negedge clk);
      bus.req = '0;
      checkOutput("t5_err_illegal", int'(bus.err_illegal), 1);
      checkOutput("t5_no_grant", int'(bus.grant), 0);
      checkOutput("t5_not_busy", int'(bus.busy), 0);
      @(negedge clk);
      checkOutput("t5_err_illegal_pulse", int'(bus.err_illegal), 0);
      checkOutput("t5_no_ack", int'(bus.ack), 0);
      applyStimulus(3'b000, 6'b000010, 24'h000101);
      pushExp(EV_HDR, 8'h20, 3'b001); pushExp(EV_ACK, 8'h00, 3'b000);
      pushExp(EV_HDR, 8'h04, 3'b010); pushExp(EV_ACK, 8'h00, 3'b000);
      serveRequests(3'b011, 2);

      // Reset during XFER aborts with no ack, then ID2 is granted first
      @(negedge clk);
      applyStimulus(3'b001, 6'b000010, 24'h000005);
      pushExp(EV_HDR, 8'h20, 3'b001);
      @(negedge clk);
      bus.req = '0;
      repeat (4) @(negedge clk);
      bus.mon_valid = 1'b1;
      repeat (2) @(negedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checkOutput("t6_async_grant", int'(bus.grant), 0);
      checkOutput("t6_async_busy", int'(bus.busy), 0);
      checkOutput("t6_async_ack", int'(bus.ack), 0);
      bus.mon_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("t6_idle_after", int'(bus.busy), 0);
      applyStimulus(3'b000, 6'b000000, 24'h010000);
      pushExp(EV_HDR, 8'h08, 3'b100);
      pushExp(EV_ACK, 8'h00, 3'b000);
      serveRequests(3'b100, 1);

      repeat (4) @(negedge clk);
      checkOutput("sb_drained", expq.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Transaction scheduler for the shared crypto interconnect bus, sitting behind the control port (ID 3) of the bus interface. It arbitrates round-robin between requesters ID 0..2 and emits the header byte through the control port's send interface. It then counts payload beats from the granted source and closes every transaction with a one-cycle `ack` broadcast to all bus interfaces. A watchdog prevents a stalled owner from holding the bus.

## Interface
- `TIMEOUT`, default 255: idle cycles allowed in XFER between payload beats before forced close.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset. Asynchronous, active-low.
- `req`  in  3  request per module ID 0..2. Level, held until granted.
- `req_dest`  in  6  destination ID per requester; `[2i+1:2i]` belongs to ID i.
- `req_len`  in  24  payload beat count per requester; `[8i+7:8i]` belongs to ID i.
- `grant`  out  3  one-hot grant to the current transaction owner.
- `hdr_valid`  out  1  header valid. Drives `send_valid` of the control port.
- `hdr_data`  out  8  header byte. Drives `send_data` of the control port.
- `hdr_ready`  in  1  from `send_ready` of the control port.
- `mon_valid`  in  1  from `recv_valid` of the control port. The control port sees every bus beat.
- `ack`  out  1  end-of-transaction pulse to every bus interface's `ack`.
- `busy`  out  1  high in every state except IDLE.
- `err_timeout`  out  1  one-cycle pulse when the watchdog closes a transaction.
- `err_illegal`  out  1  one-cycle pulse when a request is rejected because dest equals source.

## Operation
- Header format: `{2'b00, dest[1:0], src[1:0], 2'b00}`.
- FSM states: IDLE, HDR, WAIT, XFER, ACK.
- **IDLE**
  - If any `req` bit is set, the round-robin arbiter picks the winner. Search starts at `last+1` mod 3.
  - Capture winner ID, dest and len, then go to HDR.
  - If the winner has dest == src: pulse `err_illegal`, update `last` to the winner, stay in IDLE, issue no grant.
  - Dest = 3 is legal.
- **HDR**
  - `hdr_valid`=1 and `grant`=one-hot(winner).
  - On `hdr_valid && hdr_ready`, go to WAIT.
  - Hold the header stable until accepted.
- **WAIT**
  - Lasts exactly 3 cycles, giving the owner's bus interface time to take ownership.
  - `mon_valid` beats during WAIT are not counted.
  - Exit to XFER. If len == 0, exit directly to ACK instead.
- **XFER**
  - Each `mon_valid` cycle increments an 8-bit beat counter and clears the watchdog.
  - When count reaches len, go to ACK.
  - Watchdog counts cycles without `mon_valid`. When it reaches TIMEOUT, pulse `err_timeout` and go to ACK.
- **ACK**
  - `ack`=1 for exactly one cycle and `grant`=0.
  - Update `last` to the winner, clear counters, return to IDLE.
- New requests arriving during a transaction wait; they are evaluated only in IDLE.
- Dropping a request after grant has no effect; the transaction runs to count or timeout.
- Counters are 8-bit.
  - len 255 is the maximum.
  - The watchdog width is $clog2(TIMEOUT+1).
  - Neither counter wraps; both saturate or clear on state exit.

## Timing
- **Reset values:** state IDLE, `grant`=0, `hdr_valid`=0, `hdr_data`=0, `ack`=0, `busy`=0, both error pulses 0, counters 0, `last`=2 (so ID 0 wins first).
- Reset mid-transaction aborts immediately to IDLE. No `ack` is generated.
- All outputs are registered or decoded from the state register. There is no combinational path from `req` to outputs.
- **Request to header:** `req` high in IDLE at edge N gives `hdr_valid`/`grant` from cycle N+1.
- With `hdr_ready`=1, the header is accepted at N+1. WAIT covers N+2..N+4 and XFER starts at N+5.
- The last counted beat at edge M raises `ack` in cycle M+1. IDLE is entered at M+2, and a new grant is possible from M+3.
- **Back-to-back:** minimum gap between `ack` and the next `hdr_valid` is 1 IDLE cycle.
- A beat coinciding with the watchdog expiry is counted. If that beat completes len, no `err_timeout` is raised.

## Structure
- Shared package `bus_pkg`, with the contents below. The data-bus block reuses the ID constants and field positions.
  - ID constants: `ID_CTRL`=3, `NUM_REQ`=3.
  - Header field positions: SRC [3:2], DEST [5:4].
  - FSM state enum.
- Sub-module `rr_arbiter`: 3-way round-robin priority encoder.
  - Inputs: `req`, `last`.
  - Outputs: one-hot winner and `any`. Purely combinational.

## Test plan
- Reset, then `req`=3'b001, dest=2, len=4, `hdr_ready`=1, four `mon_valid` beats after WAIT -> header 8'h20, `grant`=001 from N+1, one `ack` pulse after the 4th beat, `busy` low after.
- `req`=3'b111 held, len=1 each -> grants in order 001, 010, 100, 001. Headers 0x??: the ID-2 header with dest 0 is 8'h08.
- `hdr_ready` low for 5 cycles in HDR -> `hdr_data` stable, stays in HDR, WAIT starts the cycle after acceptance.
- len=3, only 1 beat, TIMEOUT=8 -> `err_timeout` pulse and `ack` after 8 idle cycles. Next request is granted normally.
- `req`=3'b010 with dest=1 -> `err_illegal` pulse, no grant, no `ack`. Then `req`=3'b011 -> ID 0 is granted first, since `last` is 1.
- `rst_n` asserted during XFER -> outputs return to reset values asynchronously, no `ack`. After release, `req`=3'b100 is granted.
